// File: rtl/arbiter_n_to_1_request_wrr.sv
// arbiter_n_to_1_request_wrr: per-channel request FIFOs merged onto one valid/ready port
// by weighted round-robin or fixed priority, with sticky overflow flags.
module arbiter_n_to_1_request_wrr #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int PROG_THRESH  = 6,
  parameter int WEIGHT_WIDTH = 3
) (
  input  logic                                 ap_clk,
  input  logic                                 areset_n,
  input  logic [NUM_CHANNELS-1:0]              request_in_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   request_in_payload,
  output logic [NUM_CHANNELS-1:0]              request_in_ready,
  input  logic                                 cfg_mode_in,
  input  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] cfg_weight_in,
  output logic                                 request_out_valid,
  output logic [DATA_WIDTH-1:0]                request_out_payload,
  input  logic                                 request_out_ready,
  output logic [NUM_CHANNELS-1:0]              arbiter_grant_out,
  output logic                                 fifo_empty_out,
  output logic [NUM_CHANNELS-1:0]              overflow_error_out
);
  localparam int N  = NUM_CHANNELS;
  localparam int WW = WEIGHT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [N][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [N];
  logic [AW-1:0] rd_ptr [N];
  logic [AW:0] cnt [N];
  logic [AW:0] cnt_nx [N];
  logic [N-1:0] nonempty, push, pop, ready_nx;
  logic [IW-1:0] owner, owner_nx, rr_ptr, rr_ptr_nx, win_rr, win_fp, win, sel, idx;
  logic [WW-1:0] beat_cnt, beat_cnt_nx, weight, weight_nx, cfg_w;
  logic mode, mode_nx, slot, load, keep, valid_nx, empty_nx;
  always_comb begin
    nonempty = '0;
    push = '0;
    for (int i = 0; i < N; i++) begin
      nonempty[i] = cnt[i] != '0;
      push[i] = request_in_valid[i] && cnt[i] != (AW+1)'(FIFO_DEPTH);
    end
  end
  // Scan from farthest to nearest so the first non-empty channel after rr_ptr wins.
  always_comb begin
    win_rr = rr_ptr;
    win_fp = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N);
      if (nonempty[idx]) win_rr = idx;
    end
    for (int i = N - 1; i >= 0; i--) if (nonempty[i]) win_fp = IW'(i);
  end
  always_comb begin
    win = cfg_mode_in ? win_fp : win_rr;
    cfg_w = cfg_weight_in[win*WW +: WW];
    slot = !request_out_valid || request_out_ready;
    load = slot && |nonempty;
    keep = state == BURST && !mode && nonempty[owner] && beat_cnt < weight;
    sel = keep ? owner : win;
    pop = load ? N'(1) << sel : '0;
    state_nx = load ? BURST : slot ? IDLE : state;
    owner_nx = load ? sel : owner;
    rr_ptr_nx = load && !keep ? win : rr_ptr;
    beat_cnt_nx = !load ? beat_cnt : keep ? beat_cnt + WW'(beat_cnt != '1) : WW'(1);
    weight_nx = load && !keep ? (cfg_w == '0 ? WW'(1) : cfg_w) : weight;
    mode_nx = load && !keep ? cfg_mode_in : mode;
    valid_nx = load || !slot;
    empty_nx = !valid_nx;
    ready_nx = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nx[i] = cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      ready_nx[i] = cnt_nx[i] < (AW+1)'(PROG_THRESH);
      if (cnt_nx[i] != '0) empty_nx = 1'b0;
    end
  end
  assign arbiter_grant_out = state == BURST ? N'(1) << owner : '0;
  always_ff @(posedge ap_clk)
    for (int i = 0; i < N; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= request_in_payload[i*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= IW'(N - 1);
      beat_cnt <= '0;
      weight <= '0;
      mode <= 1'b0;
      request_out_valid <= 1'b0;
      request_out_payload <= '0;
      request_in_ready <= '0;
      fifo_empty_out <= 1'b0;
      overflow_error_out <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr_ptr <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      weight <= weight_nx;
      mode <= mode_nx;
      request_out_valid <= valid_nx;
      if (load) request_out_payload <= mem[sel][rd_ptr[sel]];
      request_in_ready <= ready_nx;
      fifo_empty_out <= empty_nx;
      overflow_error_out <= overflow_error_out | (request_in_valid & ~push);
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt_nx[i];
      end
    end
  end
endmodule

// File: tb/tb_arbiter_n_to_1_request_wrr.sv
// tb_arbiter_n_to_1_request_wrr: directed vectors plus randomized traffic checked against
// a queue-based model of the arbiter.
module tb_arbiter_n_to_1_request_wrr;
  localparam int N = 4, DW = 64, DEPTH = 8, THR = 6, WW = 3;
  logic ap_clk = 0, areset_n = 0;
  logic [N-1:0] iv = '0;
  logic [N*DW-1:0] ip = '0;
  logic [N-1:0] irdy;
  logic mode = 0;
  logic [N*WW-1:0] wts = '0;
  logic ovalid, ordy = 0, empty;
  logic [DW-1:0] opay;
  logic [N-1:0] grant, ovf;

  arbiter_n_to_1_request_wrr #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .PROG_THRESH(THR), .WEIGHT_WIDTH(WW)) dut (
    .ap_clk(ap_clk), .areset_n(areset_n), .request_in_valid(iv), .request_in_payload(ip),
    .request_in_ready(irdy), .cfg_mode_in(mode), .cfg_weight_in(wts),
    .request_out_valid(ovalid), .request_out_payload(opay), .request_out_ready(ordy),
    .arbiter_grant_out(grant), .fifo_empty_out(empty), .overflow_error_out(ovf));

  always #5 ap_clk = ~ap_clk;

  typedef logic [DW-1:0] q_t [$];
  q_t q [N];
  logic [DW-1:0] out_log [$];
  int total = 0, bad = 0;
  bit m_valid, m_mode, m_empty;
  logic [DW-1:0] m_payload;
  int m_owner, m_rr, m_beats, m_wt;
  logic [N-1:0] m_ready, m_ovf;

  typedef struct packed {logic rdy; logic [N-1:0] gnt; logic [DW-1:0] pay;} vec_t;
  vec_t tbl [15];

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int queued();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_valid = 0; m_payload = '0; m_owner = -1; m_rr = N - 1; m_beats = 0; m_wt = 1;
    m_mode = 0; m_ready = '0; m_ovf = '0; m_empty = 0;
  endtask

  // Advance the model by one clock using the current inputs, then compare after the edge.
  task automatic tick();
    bit full [N];
    bit keep, slot;
    int w, c, wt;
    if (ovalid && ordy) out_log.push_back(opay);
    if (areset_n) begin
      w = -1;
      slot = !m_valid || ordy;
      for (int i = 0; i < N; i++) full[i] = q[i].size() == DEPTH;
      if (slot && queued() > 0) begin
        keep = m_owner >= 0 && !m_mode && q[m_owner].size() > 0 && m_beats < m_wt;
        if (keep) begin
          w = m_owner;
          if (m_beats < 7) m_beats++;
        end else begin
          for (int k = 0; k < N; k++) begin
            c = mode ? k : (m_rr + 1 + k) % N;
            if (w < 0 && q[c].size() > 0) w = c;
          end
          wt = int'(wts[w*WW +: WW]);
          m_owner = w; m_rr = w; m_beats = 1; m_wt = wt == 0 ? 1 : wt; m_mode = mode;
        end
        m_payload = q[w].pop_front();
        m_valid = 1;
      end else if (slot) begin
        m_valid = 0;
        m_owner = -1;
      end
      for (int i = 0; i < N; i++)
        if (iv[i]) begin
          if (full[i]) m_ovf[i] = 1;
          else q[i].push_back(ip[i*DW +: DW]);
        end
      for (int i = 0; i < N; i++) m_ready[i] = q[i].size() < THR;
      m_empty = !m_valid && queued() == 0;
    end
    @(posedge ap_clk);
    #1;
    check("valid", DW'(ovalid), DW'(m_valid));
    if (m_valid) check("payload", opay, m_payload);
    check("grant", DW'(grant), m_owner < 0 ? '0 : DW'(1) << m_owner);
    check("in_ready", DW'(irdy), DW'(m_ready));
    check("empty", DW'(empty), DW'(m_empty));
    check("overflow", DW'(ovf), DW'(m_ovf));
  endtask

  task automatic do_reset();
    iv = '0;
    areset_n = 0;
    model_reset();
    tick();
    areset_n = 1;
    tick();
  endtask

  task automatic drain();
    iv = '0;
    ordy = 1;
    for (int c = 0; c < 80 && !m_empty; c++) tick();
    check("drain_done", DW'(empty), DW'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int j;
    tbl[0]  = '{1'b1, 4'b0010, 64'h10};
    tbl[1]  = '{1'b1, 4'b0010, 64'h11};
    tbl[2]  = '{1'b1, 4'b0100, 64'h20};
    tbl[3]  = '{1'b1, 4'b1000, 64'h30};
    tbl[4]  = '{1'b0, 4'b1000, 64'h30};
    tbl[5]  = '{1'b1, 4'b1000, 64'h31};
    tbl[6]  = '{1'b1, 4'b1000, 64'h32};
    tbl[7]  = '{1'b1, 4'b0001, 64'h01};
    tbl[8]  = '{1'b1, 4'b0010, 64'h12};
    tbl[9]  = '{1'b1, 4'b0010, 64'h13};
    tbl[10] = '{1'b1, 4'b0100, 64'h21};
    tbl[11] = '{1'b1, 4'b1000, 64'h33};
    tbl[12] = '{1'b1, 4'b1000, 64'h34};
    tbl[13] = '{1'b1, 4'b1000, 64'h35};
    tbl[14] = '{1'b1, 4'b0001, 64'h02};
    model_reset();
    do_reset();
    check("rst_ready", DW'(irdy), DW'(4'hF));
    check("rst_empty", DW'(empty), DW'(1));

    ordy = 1;
    ip[2*DW +: DW] = 64'hAB;
    iv = 4'b0100;
    tick();
    check("lat_not_yet", DW'(ovalid), DW'(0));
    iv = '0;
    tick();
    check("lat_valid", DW'(ovalid), DW'(1));
    check("lat_payload", opay, 64'hAB);
    check("lat_grant", DW'(grant), DW'(4'b0100));
    drain();

    wts = {3'd3, 3'd1, 3'd2, 3'd1};
    do_reset();
    ordy = 0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) ip[i*DW +: DW] = DW'(i * 16 + n);
      iv = 4'hF;
      tick();
    end
    iv = '0;
    check("wrr_first_grant", DW'(grant), DW'(4'b0001));
    check("wrr_first_payload", opay, 64'h00);
    for (int r = 0; r < 15; r++) begin
      ordy = tbl[r].rdy;
      tick();
      check("wrr_tbl_valid", DW'(ovalid), DW'(1));
      check("wrr_tbl_grant", DW'(grant), DW'(tbl[r].gnt));
      check("wrr_tbl_payload", opay, tbl[r].pay);
    end
    drain();

    mode = 1;
    out_log.delete();
    for (int n = 0; n < 16; n++) begin
      ip[3*DW +: DW] = DW'(12'h300 + n);
      ip[1*DW +: DW] = DW'(12'h100 + n - 5);
      iv = (n >= 5 && n <= 7) ? 4'b1010 : 4'b1000;
      tick();
    end
    drain();
    mode = 0;
    j = -1;
    for (int k = 0; k < out_log.size(); k++) if (j < 0 && (out_log[k] >> 8) == 1) j = k;
    check("fp_count", DW'(out_log.size()), DW'(19));
    check("fp_found", DW'(j >= 0 && j + 3 < out_log.size()), DW'(1));
    if (j >= 0 && j + 3 < out_log.size()) begin
      for (int k = 0; k < 3; k++) check("fp_ch1_burst", out_log[j+k], DW'(12'h100 + k));
      check("fp_ch3_resume", out_log[j+3] >> 8, DW'(3));
    end

    do_reset();
    ordy = 0;
    for (int n = 0; n < 10; n++) begin
      ip[0 +: DW] = DW'(8'h40 + n);
      iv = 4'b0001;
      tick();
      if (n == 5) check("thr_ready_hi", DW'(irdy[0]), DW'(1));
      if (n == 6) check("thr_ready_lo", DW'(irdy[0]), DW'(0));
      if (n == 8) check("ovf_clear", DW'(ovf[0]), DW'(0));
      if (n == 9) check("ovf_set", DW'(ovf[0]), DW'(1));
    end
    iv = '0;
    tick();
    check("stall_valid", DW'(ovalid), DW'(1));
    check("stall_payload", opay, 64'h40);
    out_log.delete();
    drain();
    check("ovf_drain_count", DW'(out_log.size()), DW'(9));
    for (int k = 0; k < out_log.size() && k < 9; k++) check("ovf_order", out_log[k], DW'(8'h40 + k));

    ordy = 0;
    for (int n = 0; n < 6; n++) begin
      ip[1*DW +: DW] = DW'(8'h50 + n);
      iv = 4'b0010;
      tick();
    end
    iv = '0;
    #2;
    areset_n = 0;
    #1;
    model_reset();
    check("arst_valid", DW'(ovalid), DW'(0));
    check("arst_payload", opay, '0);
    check("arst_grant", DW'(grant), '0);
    check("arst_ready", DW'(irdy), '0);
    check("arst_empty", DW'(empty), '0);
    check("arst_ovf", DW'(ovf), '0);
    tick();
    areset_n = 1;
    tick();
    check("arst_rel_empty", DW'(empty), DW'(1));
    ordy = 1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("arst_no_emit", DW'(ovalid), DW'(0));
    end

    wts = {3'd1, 3'd1, 3'd0, 3'd1};
    do_reset();
    ordy = 0;
    for (int n = 0; n < 4; n++) begin
      ip[1*DW +: DW] = DW'(8'h60 + n);
      ip[2*DW +: DW] = DW'(8'h70 + n);
      iv = 4'b0110;
      tick();
    end
    iv = '0;
    check("w0_first", DW'(grant), DW'(4'b0010));
    ordy = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("w0_alternate", DW'(grant), (k % 2 == 0) ? DW'(4'b0100) : DW'(4'b0010));
    end
    drain();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) ip[i*DW +: DW] = {$urandom(), $urandom()};
      iv = N'($urandom() & $urandom());
      ordy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      if (c % 40 == 0) wts = (N*WW)'($urandom());
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
